madd_seq_approx: RTL

- Parametrised, sequential successor to the fixed-width combinational approximate multiply-add cores: computes y = a*b + c over WIDTH-bit operands with an iterative shift-add datapath.
- Runtime mode selects an exact result or an approximate one with truncated partial-product columns.
- An exact shadow accumulator runs alongside, so every result reports its error magnitude and an error-threshold flag.
- Sits in the approximate-arithmetic evaluation path, with valid/ready handshakes on both sides.

---
 rtl/madd_seq_approx_if.sv | 33 +++
 rtl/madd_seq_approx.sv | 138 +++++++++++++
 2 files changed

// File: rtl/madd_seq_approx_if.sv
// Operand/result bus for madd_seq_approx.
//
// Handshake semantics (both directions): a transfer happens on a rising clock
// edge where valid && ready are both high. The source holds valid and its
// payload stable until that edge. The sink may raise or lower ready at any
// time. Input side: the master drives in_valid/a/b/c/approx and the block
// drives in_ready. Output side: the block drives out_valid/y/err_mag/err_flag
// and the master drives out_ready.
interface madd_seq_approx_if #(
    parameter int WIDTH = 2
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     c;
    logic                 approx;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   y;
    logic [2*WIDTH-1:0]   err_mag;
    logic                 err_flag;

    modport master (
        output in_valid, a, b, c, approx, out_ready,
        input  in_ready, out_valid, y, err_mag, err_flag
    );

    modport slave (
        input  in_valid, a, b, c, approx, out_ready,
        output in_ready, out_valid, y, err_mag, err_flag
    );
endinterface

// File: rtl/madd_seq_approx.sv
// Sequential approximate multiply-add: y = a*b + c via shift-add, one bit of
// b per cycle. An exact shadow accumulator runs in parallel so each result
// carries its error magnitude, a threshold flag, and feeds a saturating
// violation counter.
//
// Cycle plan: accept edge -> WIDTH accumulate cycles (steps 0..WIDTH-1) ->
// one finalize cycle (step == WIDTH) that registers the outputs -> DONE.
// out_valid therefore rises WIDTH+1 cycles after the accept edge.
module madd_seq_approx #(
    parameter int WIDTH = 2,
    parameter int TRUNC = 1,
    parameter int ET    = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    madd_seq_approx_if.slave bus,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [1:0]       state_dbg
);
    localparam int RW = 2 * WIDTH;
    localparam int SW = $clog2(WIDTH + 1);
    // Keeps partial-product columns at or above TRUNC in approximate mode.
    localparam logic [RW-1:0] TMASK = ~((RW'(1) << TRUNC) - RW'(1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [SW-1:0]    step_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             approx_q;
    logic [RW-1:0]    acc_exa_q, acc_apx_q;
    logic [RW-1:0]    y_q, err_q;
    logic             flag_q;
    logic [CNT_W-1:0] viol_q;

    logic             in_ready, out_valid;
    logic             accept, deliver, last_step;
    logic [WIDTH-1:0] b_shift;
    logic [RW-1:0]    pp, pp_apx, err_now;

    // Partial product for the current step plus the running error.
    always_comb begin
        b_shift   = b_q >> step_q;
        pp        = b_shift[0] ? ({{WIDTH{1'b0}}, a_q} << step_q) : '0;
        pp_apx    = approx_q ? (pp & TMASK) : pp;
        err_now   = acc_exa_q - acc_apx_q;
        last_step = (step_q == SW'(WIDTH));
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_n   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_n = MUL;
            end
            MUL: begin
                if (last_step) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign accept  = in_ready & bus.in_valid;
    assign deliver = out_valid & bus.out_ready;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_n;
    end

    // Operand capture, shift-add accumulation and output registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            approx_q  <= 1'b0;
            acc_exa_q <= '0;
            acc_apx_q <= '0;
            y_q       <= '0;
            err_q     <= '0;
            flag_q    <= 1'b0;
        end else begin
            if (accept) begin
                a_q       <= bus.a;
                b_q       <= bus.b;
                approx_q  <= bus.approx;
                acc_exa_q <= {{WIDTH{1'b0}}, bus.c};
                acc_apx_q <= {{WIDTH{1'b0}}, bus.c};
                step_q    <= '0;
            end else if (state_q == MUL) begin
                if (last_step) begin
                    y_q    <= acc_apx_q;
                    err_q  <= err_now;
                    flag_q <= (err_now > RW'(ET));
                end else begin
                    acc_exa_q <= acc_exa_q + pp;
                    acc_apx_q <= acc_apx_q + pp_apx;
                    step_q    <= step_q + SW'(1);
                end
            end
        end
    end

    // Saturating count of delivered flagged results; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_q <= '0;
        end else if (clr_stats) begin
            viol_q <= '0;
        end else if (deliver && flag_q && (viol_q != {CNT_W{1'b1}})) begin
            viol_q <= viol_q + CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.y         = y_q;
    assign bus.err_mag   = err_q;
    assign bus.err_flag  = flag_q;
    assign viol_cnt      = viol_q;
    assign state_dbg     = state_q;
endmodule
